// File: rtl/cpu_mul_pipe.sv
// Pipelined integer multiply unit: four half-width partial products registered in stage 1, summed and word-selected after.
// Optional feature macro: CPU_MUL_PIPE_MULX_EN enables the high-word/signed MULX ops; without it every op returns the low word.
module cpu_mul_pipe #(
  parameter int DATA_W  = 32,
  parameter int OUT_REG = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic [1:0]        E_op,
  input  logic              E_valid,
  input  logic              M_en,
  output logic [DATA_W-1:0] M_result,
  output logic              M_valid
);

  localparam int H = DATA_W / 2;

  logic [H-1:0]      al_s, ah_s, bl_s, bh_s;
  logic [DATA_W-1:0] pp_ll_s, pp_lh_s, pp_hl_s;
  logic [DATA_W-1:0] pp_ll_r, pp_lh_r, pp_hl_r;
  logic              valid_r;
  logic [DATA_W-1:0] sel_s;

  assign al_s = E_src1[H-1:0];
  assign ah_s = E_src1[DATA_W-1:H];
  assign bl_s = E_src2[H-1:0];
  assign bh_s = E_src2[DATA_W-1:H];

  assign pp_ll_s = DATA_W'(al_s) * DATA_W'(bl_s);
  assign pp_lh_s = DATA_W'(al_s) * DATA_W'(bh_s);
  assign pp_hl_s = DATA_W'(ah_s) * DATA_W'(bl_s);

  // Stage 1: low/cross partial products and valid, frozen while M_en is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pp_ll_r <= {DATA_W{1'b0}};
      pp_lh_r <= {DATA_W{1'b0}};
      pp_hl_r <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
    end else if (M_en) begin
      pp_ll_r <= pp_ll_s;
      pp_lh_r <= pp_lh_s;
      pp_hl_r <= pp_hl_s;
      valid_r <= E_valid;
    end
  end

`ifdef CPU_MUL_PIPE_MULX_EN
  localparam int W2 = 2 * DATA_W;

  logic [DATA_W-1:0] pp_hh_s, pp_hh_r, a_r, b_r;
  logic [1:0]        op_r;
  logic              sa_r, sb_r;
  logic [W2-1:0]     mid_s, p_s, corr_s;

  assign pp_hh_s = DATA_W'(ah_s) * DATA_W'(bh_s);

  // Stage 1: high partial product plus what the signed correction needs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pp_hh_r <= {DATA_W{1'b0}};
      a_r     <= {DATA_W{1'b0}};
      b_r     <= {DATA_W{1'b0}};
      op_r    <= 2'b00;
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
    end else if (M_en) begin
      pp_hh_r <= pp_hh_s;
      a_r     <= E_src1;
      b_r     <= E_src2;
      op_r    <= E_op;
      sa_r    <= E_src1[DATA_W-1];
      sb_r    <= E_src2[DATA_W-1];
    end
  end

  // Full-width sum, two's-complement correction of the high word, and word select.
  always_comb begin
    corr_s = {W2{1'b0}};
    mid_s  = {{DATA_W{1'b0}}, pp_lh_r} + {{DATA_W{1'b0}}, pp_hl_r};
    case (op_r)
      2'b10: begin
        if (sa_r) corr_s = {b_r, {DATA_W{1'b0}}};
        else      corr_s = {W2{1'b0}};
      end
      2'b11: begin
        if (sa_r) corr_s = {b_r, {DATA_W{1'b0}}};
        else      corr_s = {W2{1'b0}};
        if (sb_r) corr_s = corr_s + {a_r, {DATA_W{1'b0}}};
        else      corr_s = corr_s;
      end
      default: corr_s = {W2{1'b0}};
    endcase
    p_s = {{DATA_W{1'b0}}, pp_ll_r} + (mid_s << H) + {pp_hh_r, {DATA_W{1'b0}}} - corr_s;
    case (op_r)
      2'b00:   sel_s = p_s[DATA_W-1:0];
      default: sel_s = p_s[W2-1:DATA_W];
    endcase
  end
`else
  logic unused_op_s;

  // Op select is not decoded in this build.
  assign unused_op_s = ^E_op;

  // Low word only; the high partial product cannot reach it.
  always_comb begin
    sel_s = pp_ll_r + ((pp_lh_r + pp_hl_r) << H);
  end
`endif

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] result_r;
      logic              out_valid_r;

      // Stage 2: registered result and valid.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          result_r    <= {DATA_W{1'b0}};
          out_valid_r <= 1'b0;
        end else if (M_en) begin
          result_r    <= sel_s;
          out_valid_r <= valid_r;
        end
      end

      assign M_result = result_r;
      assign M_valid  = out_valid_r;
    end else begin : g_out_comb
      assign M_result = sel_s;
      assign M_valid  = valid_r;
    end
  endgenerate

endmodule

// File: tb/tb_cpu_mul_pipe.sv
// Directed self-checking bench: a 32-bit registered-output instance and a 16-bit single-stage instance.
// Expected high-word results depend on CPU_MUL_PIPE_MULX_EN.
module tb_cpu_mul_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m_en = 1'b1;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic [1:0]  op = 2'b00;
  logic        v = 1'b0;
  logic [31:0] res;
  logic        res_v;
  logic [15:0] a16 = 16'd0, b16 = 16'd0;
  logic [1:0]  op16 = 2'b00;
  logic        v16 = 1'b0;
  logic [15:0] res16;
  logic        res16_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_mul_pipe #(.DATA_W(32), .OUT_REG(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .E_src1(a), .E_src2(b), .E_op(op), .E_valid(v),
    .M_en(m_en), .M_result(res), .M_valid(res_v)
  );

  cpu_mul_pipe #(.DATA_W(16), .OUT_REG(0)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .E_src1(a16), .E_src2(b16), .E_op(op16), .E_valid(v16),
    .M_en(m_en), .M_result(res16), .M_valid(res16_v)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    n_checks++; if (res_v !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", res_v); end
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 00000000", res); end
    n_checks++; if (res16_v !== 1'b0) begin n_fail++; $display("FAIL reset_valid16: got %b want 0", res16_v); end
  endtask

  task automatic test_mul();
    a = 32'h0001_0003; b = 32'h0002_0005; op = 2'b00; v = 1'b1;
    cyc();
    v = 1'b0;
    n_checks++; if (res_v !== 1'b0) begin n_fail++; $display("FAIL mul_early_valid: got %b want 0", res_v); end
    cyc();
    n_checks++; if (res !== 32'h000B_000F) begin n_fail++; $display("FAIL mul_result: got %h want 000b000f", res); end
    n_checks++; if (res_v !== 1'b1) begin n_fail++; $display("FAIL mul_valid: got %b want 1", res_v); end
    cyc();
    n_checks++; if (res_v !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b want 0", res_v); end
  endtask

  task automatic test_mulx();
    logic [31:0] exp_uu, exp_ss, exp_su;
`ifdef CPU_MUL_PIPE_MULX_EN
    exp_uu = 32'hFFFF_FFFE; exp_ss = 32'h0000_0000; exp_su = 32'hFFFF_FFFF;
`else
    exp_uu = 32'h0000_0001; exp_ss = 32'h0000_0001; exp_su = 32'hFFFF_FFFE;
`endif
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; op = 2'b01; v = 1'b1;
    cyc();
    op = 2'b11;
    cyc();
    n_checks++; if (res !== exp_uu) begin n_fail++; $display("FAIL mulxuu: got %h want %h", res, exp_uu); end
    b = 32'h0000_0002; op = 2'b10;
    cyc();
    n_checks++; if (res !== exp_ss) begin n_fail++; $display("FAIL mulxss: got %h want %h", res, exp_ss); end
    v = 1'b0; op = 2'b00;
    cyc();
    n_checks++; if (res !== exp_su) begin n_fail++; $display("FAIL mulxsu: got %h want %h", res, exp_su); end
    n_checks++; if (res_v !== 1'b1) begin n_fail++; $display("FAIL mulxsu_valid: got %b want 1", res_v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      a = 32'(i + 1); b = 32'(i + 3); v = (i < 4);
      cyc();
      if (i >= 1) begin
        exp = 32'(i * (i + 2));
        n_checks++; if (res !== exp) begin n_fail++; $display("FAIL b2b_result[%0d]: got %0d want %0d", i, res, exp); end
        n_checks++; if (res_v !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, res_v); end
      end
    end
  endtask

  task automatic test_stall();
    a = 32'd2; b = 32'd3; v = 1'b1; op = 2'b00;
    cyc();
    a = 32'd7; b = 32'd9;
    cyc();
    m_en = 1'b0; a = 32'd5; b = 32'd5;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_checks++; if (res !== 32'd6) begin n_fail++; $display("FAIL stall_hold[%0d]: got %0d want 6", k, res); end
      n_checks++; if (res_v !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", k, res_v); end
    end
    m_en = 1'b1; v = 1'b0;
    cyc();
    n_checks++; if (res !== 32'd63) begin n_fail++; $display("FAIL stall_result: got %0d want 63", res); end
    n_checks++; if (res_v !== 1'b1) begin n_fail++; $display("FAIL stall_result_valid: got %b want 1", res_v); end
    cyc();
    n_checks++; if (res_v !== 1'b0) begin n_fail++; $display("FAIL stall_no_dup: got %b want 0", res_v); end
  endtask

  task automatic test_reset_midflight();
    a = 32'd3; b = 32'd3; v = 1'b1; op = 2'b00;
    cyc();
    a = 32'd4; b = 32'd4;
    cyc();
    v = 1'b0;
    n_checks++; if (res !== 32'd9) begin n_fail++; $display("FAIL inflight_result: got %0d want 9", res); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (res_v !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", res_v); end
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL rst_mid_result: got %h want 0", res); end
    cyc();
    reset_n = 1'b1;
    cyc();
    n_checks++; if (res_v !== 1'b0) begin n_fail++; $display("FAIL rst_stale1: got %b want 0", res_v); end
    cyc();
    n_checks++; if (res_v !== 1'b0) begin n_fail++; $display("FAIL rst_stale2: got %b want 0", res_v); end
    a = 32'd5; b = 32'd5; v = 1'b1;
    cyc();
    v = 1'b0;
    cyc();
    n_checks++; if (res !== 32'd25) begin n_fail++; $display("FAIL post_rst_result: got %0d want 25", res); end
    n_checks++; if (res_v !== 1'b1) begin n_fail++; $display("FAIL post_rst_valid: got %b want 1", res_v); end
  endtask

  task automatic test_narrow_single_stage();
    logic [15:0] exp_ss;
`ifdef CPU_MUL_PIPE_MULX_EN
    exp_ss = 16'h4000;
`else
    exp_ss = 16'h0000;
`endif
    a16 = 16'h8000; b16 = 16'h8000; op16 = 2'b11; v16 = 1'b1;
    #1;
    n_checks++; if (res16_v !== 1'b0) begin n_fail++; $display("FAIL n16_not_comb_valid: got %b want 0", res16_v); end
    cyc();
    n_checks++; if (res16 !== exp_ss) begin n_fail++; $display("FAIL n16_mulxss: got %h want %h", res16, exp_ss); end
    n_checks++; if (res16_v !== 1'b1) begin n_fail++; $display("FAIL n16_valid: got %b want 1", res16_v); end
    a16 = 16'h00FF; b16 = 16'h0101; op16 = 2'b00;
    cyc();
    n_checks++; if (res16 !== 16'hFFFF) begin n_fail++; $display("FAIL n16_mul: got %h want ffff", res16); end
    v16 = 1'b0;
    cyc();
    n_checks++; if (res16_v !== 1'b0) begin n_fail++; $display("FAIL n16_bubble: got %b want 0", res16_v); end
  endtask

  initial begin
    test_reset();
    test_narrow_single_stage();
    test_mul();
    test_mulx();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
